// File: rtl/clock_div_prog_multi_if.sv
`default_nettype none
// ============================================================================
// Module      : clock_div_prog_multi_if
// Description : Control/status bundle for the multi-channel programmable
//               clock divider (enables, ratio loads, divided clocks, ticks).
// Revision    : 1.0 - initial release
// ============================================================================
interface clock_div_prog_multi_if #(
  parameter int N_CH      = 3,
  parameter int CNT_WIDTH = 17
);

  logic [N_CH-1:0]           ENABLE_IN;
  logic [N_CH-1:0]           LOAD_IN;
  logic [N_CH*CNT_WIDTH-1:0] DIV_IN;
  logic [N_CH-1:0]           CLK_OUT;
  logic [N_CH-1:0]           TICK_OUT;
  logic [N_CH-1:0]           PEND_OUT;

  // Controller side: drives enables and ratio loads, observes divider outputs
  modport master (
    output ENABLE_IN, LOAD_IN, DIV_IN,
    input  CLK_OUT, TICK_OUT, PEND_OUT
  );

  // Divider side
  modport slave (
    input  ENABLE_IN, LOAD_IN, DIV_IN,
    output CLK_OUT, TICK_OUT, PEND_OUT
  );

endinterface
`default_nettype wire

// File: rtl/clock_div_prog_multi.sv
`default_nettype none
// ============================================================================
// Module      : clock_div_prog_multi
// Description : N_CH independent programmable clock dividers sharing one
//               system clock. Ratio loads are staged and only take effect at
//               a period boundary (or immediately while a channel is idle),
//               so the divided clocks never glitch.
// Revision    : 1.0 - initial release
// ============================================================================
module clock_div_prog_multi #(
  parameter int N_CH        = 3,
  parameter int CNT_WIDTH   = 17,
  parameter int DEFAULT_DIV = 10
) (
  input  wire logic            CLK_IN,
  input  wire logic            RESET_IN,
  clock_div_prog_multi_if.slave bus
);

  localparam logic [CNT_WIDTH-1:0] c_ONE     = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] c_TWO     = CNT_WIDTH'(2);
  localparam logic [CNT_WIDTH-1:0] c_DEF_DIV = CNT_WIDTH'(DEFAULT_DIV);
  localparam logic [CNT_WIDTH:0]   c_HALF_RND = (CNT_WIDTH+1)'(1);

  for (genvar k = 0; k < N_CH; k++) begin : g_ch
    logic [CNT_WIDTH-1:0] r_cnt;
    logic [CNT_WIDTH-1:0] r_div;
    logic [CNT_WIDTH-1:0] r_pend_div;
    logic                 r_pend_v;
    logic                 r_clk;
    logic                 r_tick;

    logic [CNT_WIDTH-1:0] w_div_in;
    logic [CNT_WIDTH-1:0] w_load_val;
    logic                 w_wrap;
    logic [CNT_WIDTH-1:0] w_wrap_div;
    logic [CNT_WIDTH-1:0] w_next_cnt;
    logic [CNT_WIDTH:0]   w_half;

    // Next-state terms for an enabled edge: wrap detect, ratio hand-over,
    // next count and high-phase length (ceil(div/2)) of the ratio in force.
    always_comb begin
      w_div_in   = bus.DIV_IN[k*CNT_WIDTH +: CNT_WIDTH];
      w_load_val = (w_div_in < c_TWO) ? c_TWO : w_div_in;
      w_wrap     = (r_cnt == (r_div - c_ONE));
      w_wrap_div = r_pend_v ? r_pend_div : r_div;
      w_next_cnt = w_wrap ? '0 : (r_cnt + c_ONE);
      // Extra bit keeps (div+1) from overflowing at the maximum ratio
      w_half     = ({1'b0, (w_wrap ? w_wrap_div : r_div)} + c_HALF_RND) >> 1;
    end

    // Channel counter, staged ratio and registered clock/tick outputs
    always_ff @(posedge CLK_IN or posedge RESET_IN) begin
      if (RESET_IN) begin
        r_cnt      <= c_DEF_DIV - c_ONE;
        r_div      <= c_DEF_DIV;
        r_pend_div <= c_DEF_DIV;
        r_pend_v   <= 1'b0;
        r_clk      <= 1'b0;
        r_tick     <= 1'b0;
      end else begin
        if (bus.ENABLE_IN[k]) begin
          r_cnt  <= w_next_cnt;
          r_tick <= w_wrap;
          r_clk  <= ({1'b0, w_next_cnt} < w_half);
          if (w_wrap) begin
            r_div    <= w_wrap_div;
            r_pend_v <= 1'b0;
          end
        end else begin
          // Idle: park the counter at div-1 so re-enabling wraps at once
          r_clk  <= 1'b0;
          r_tick <= 1'b0;
          if (r_pend_v) begin
            r_div    <= r_pend_div;
            r_pend_v <= 1'b0;
            r_cnt    <= r_pend_div - c_ONE;
          end else begin
            r_cnt <= r_div - c_ONE;
          end
        end
        // A load on this edge always wins over the clear above, so a value
        // captured on a wrap edge waits for the following wrap.
        if (bus.LOAD_IN[k]) begin
          r_pend_div <= w_load_val;
          r_pend_v   <= 1'b1;
        end
      end
    end

    assign bus.CLK_OUT[k]  = r_clk;
    assign bus.TICK_OUT[k] = r_tick;
    assign bus.PEND_OUT[k] = r_pend_v;
  end

endmodule
`default_nettype wire

// File: tb/tb_clock_div_prog_multi.sv
`default_nettype none
// ============================================================================
// Module      : tb_clock_div_prog_multi
// Description : Directed self-checking bench for clock_div_prog_multi
//               (3 channels, 17-bit counters, default ratio 10).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clock_div_prog_multi;

  localparam int W = 17;

  logic clk = 1'b0;
  logic rst = 1'b0;

  int checks   = 0;
  int failures = 0;

  logic [2:0] exp_clk;
  logic [2:0] exp_tick;
  logic [2:0] exp_pend;

  clock_div_prog_multi_if #(.N_CH(3), .CNT_WIDTH(W)) bus ();

  clock_div_prog_multi #(
    .N_CH(3),
    .CNT_WIDTH(W),
    .DEFAULT_DIV(10)
  ) dut (
    .CLK_IN(clk),
    .RESET_IN(rst),
    .bus(bus)
  );

  // 10 ns system clock
  always #5 clk = ~clk;

  // Hand-derived phase: edge e of a period of length dv starting at edge off
  // gives count (e-off)%dv; high while count < ceil(dv/2); tick at count 0.
  function automatic logic [1:0] ph(input int e, input int dv, input int off);
    int c;
    c = (e - off) % dv;
    return {(c < (dv + 1) / 2), (c == 0)};
  endfunction

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.ENABLE_IN = 3'b111;
    bus.LOAD_IN   = 3'b000;
    bus.DIV_IN    = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    bus.ENABLE_IN = 3'b111;
    bus.LOAD_IN   = 3'b000;
    bus.DIV_IN    = '0;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.CLK_OUT !== 3'b000) begin
      failures++;
      $display("FAIL reset_clk got %b exp %b", bus.CLK_OUT, 3'b000);
    end
    checks++;
    if (bus.TICK_OUT !== 3'b000) begin
      failures++;
      $display("FAIL reset_tick got %b exp %b", bus.TICK_OUT, 3'b000);
    end
    checks++;
    if (bus.PEND_OUT !== 3'b000) begin
      failures++;
      $display("FAIL reset_pend got %b exp %b", bus.PEND_OUT, 3'b000);
    end
    do_reset();
  endtask

  task automatic test_defaults(input string name);
    for (int e = 1; e <= 25; e++) begin
      edge_step();
      for (int k = 0; k < 3; k++) {exp_clk[k], exp_tick[k]} = ph(e, 10, 1);
      exp_pend = 3'b000;
      checks++;
      if (bus.CLK_OUT !== exp_clk) begin
        failures++;
        $display("FAIL %s_clk e=%0d got %b exp %b", name, e, bus.CLK_OUT, exp_clk);
      end
      checks++;
      if (bus.TICK_OUT !== exp_tick) begin
        failures++;
        $display("FAIL %s_tick e=%0d got %b exp %b", name, e, bus.TICK_OUT, exp_tick);
      end
      checks++;
      if (bus.PEND_OUT !== exp_pend) begin
        failures++;
        $display("FAIL %s_pend e=%0d got %b exp %b", name, e, bus.PEND_OUT, exp_pend);
      end
    end
  endtask

  // ch1 loads 5 on edge 4; period of 10 finishes at edge 10, ratio 5 from 11
  task automatic test_odd_ratio();
    do_reset();
    for (int e = 1; e <= 30; e++) begin
      bus.LOAD_IN = (e == 4) ? 3'b010 : 3'b000;
      bus.DIV_IN[1*W +: W] = (e == 4) ? W'(5) : W'(0);
      edge_step();
      {exp_clk[0], exp_tick[0]} = ph(e, 10, 1);
      {exp_clk[2], exp_tick[2]} = ph(e, 10, 1);
      {exp_clk[1], exp_tick[1]} = (e <= 10) ? ph(e, 10, 1) : ph(e, 5, 11);
      exp_pend = (e >= 4 && e <= 10) ? 3'b010 : 3'b000;
      checks++;
      if (bus.CLK_OUT !== exp_clk) begin
        failures++;
        $display("FAIL odd_clk e=%0d got %b exp %b", e, bus.CLK_OUT, exp_clk);
      end
      checks++;
      if (bus.TICK_OUT !== exp_tick) begin
        failures++;
        $display("FAIL odd_tick e=%0d got %b exp %b", e, bus.TICK_OUT, exp_tick);
      end
      checks++;
      if (bus.PEND_OUT !== exp_pend) begin
        failures++;
        $display("FAIL odd_pend e=%0d got %b exp %b", e, bus.PEND_OUT, exp_pend);
      end
    end
  endtask

  // ch2: load 0 (edge 3) then 7 (edge 4) -> 7 at edge 11; load 1 (edge 19)
  // -> clamped to 2, applied at the wrap on edge 25
  task automatic test_clamp_back_to_back();
    do_reset();
    for (int e = 1; e <= 32; e++) begin
      bus.LOAD_IN = (e == 3 || e == 4 || e == 19) ? 3'b100 : 3'b000;
      bus.DIV_IN[2*W +: W] = (e == 4) ? W'(7) : (e == 19) ? W'(1) : W'(0);
      edge_step();
      {exp_clk[0], exp_tick[0]} = ph(e, 10, 1);
      {exp_clk[1], exp_tick[1]} = ph(e, 10, 1);
      if (e <= 10)      {exp_clk[2], exp_tick[2]} = ph(e, 10, 1);
      else if (e <= 24) {exp_clk[2], exp_tick[2]} = ph(e, 7, 11);
      else              {exp_clk[2], exp_tick[2]} = ph(e, 2, 25);
      exp_pend = ((e >= 3 && e <= 10) || (e >= 19 && e <= 24)) ? 3'b100 : 3'b000;
      checks++;
      if (bus.CLK_OUT !== exp_clk) begin
        failures++;
        $display("FAIL clamp_clk e=%0d got %b exp %b", e, bus.CLK_OUT, exp_clk);
      end
      checks++;
      if (bus.TICK_OUT !== exp_tick) begin
        failures++;
        $display("FAIL clamp_tick e=%0d got %b exp %b", e, bus.TICK_OUT, exp_tick);
      end
      checks++;
      if (bus.PEND_OUT !== exp_pend) begin
        failures++;
        $display("FAIL clamp_pend e=%0d got %b exp %b", e, bus.PEND_OUT, exp_pend);
      end
    end
  endtask

  // ch0 loads 4 on its wrap edge (edge 11): one more 10-cycle period, then 4
  task automatic test_load_on_wrap();
    do_reset();
    for (int e = 1; e <= 32; e++) begin
      bus.LOAD_IN = (e == 11) ? 3'b001 : 3'b000;
      bus.DIV_IN[0 +: W] = (e == 11) ? W'(4) : W'(0);
      edge_step();
      {exp_clk[0], exp_tick[0]} = (e <= 20) ? ph(e, 10, 1) : ph(e, 4, 21);
      {exp_clk[1], exp_tick[1]} = ph(e, 10, 1);
      {exp_clk[2], exp_tick[2]} = ph(e, 10, 1);
      exp_pend = (e >= 11 && e <= 20) ? 3'b001 : 3'b000;
      checks++;
      if (bus.CLK_OUT !== exp_clk) begin
        failures++;
        $display("FAIL wrapload_clk e=%0d got %b exp %b", e, bus.CLK_OUT, exp_clk);
      end
      checks++;
      if (bus.TICK_OUT !== exp_tick) begin
        failures++;
        $display("FAIL wrapload_tick e=%0d got %b exp %b", e, bus.TICK_OUT, exp_tick);
      end
      checks++;
      if (bus.PEND_OUT !== exp_pend) begin
        failures++;
        $display("FAIL wrapload_pend e=%0d got %b exp %b", e, bus.PEND_OUT, exp_pend);
      end
    end
  endtask

  // ch0 disabled on edges 4..6 (mid high phase), loads 6 on edge 5,
  // re-enabled from edge 7 where it must rise and tick with period 6
  task automatic test_enable_gating();
    do_reset();
    for (int e = 1; e <= 22; e++) begin
      bus.ENABLE_IN = (e >= 4 && e <= 6) ? 3'b110 : 3'b111;
      bus.LOAD_IN   = (e == 5) ? 3'b001 : 3'b000;
      bus.DIV_IN[0 +: W] = (e == 5) ? W'(6) : W'(0);
      edge_step();
      if (e <= 3)      {exp_clk[0], exp_tick[0]} = ph(e, 10, 1);
      else if (e <= 6) {exp_clk[0], exp_tick[0]} = 2'b00;
      else             {exp_clk[0], exp_tick[0]} = ph(e, 6, 7);
      {exp_clk[1], exp_tick[1]} = ph(e, 10, 1);
      {exp_clk[2], exp_tick[2]} = ph(e, 10, 1);
      exp_pend = (e == 5) ? 3'b001 : 3'b000;
      checks++;
      if (bus.CLK_OUT !== exp_clk) begin
        failures++;
        $display("FAIL enable_clk e=%0d got %b exp %b", e, bus.CLK_OUT, exp_clk);
      end
      checks++;
      if (bus.TICK_OUT !== exp_tick) begin
        failures++;
        $display("FAIL enable_tick e=%0d got %b exp %b", e, bus.TICK_OUT, exp_tick);
      end
      checks++;
      if (bus.PEND_OUT !== exp_pend) begin
        failures++;
        $display("FAIL enable_pend e=%0d got %b exp %b", e, bus.PEND_OUT, exp_pend);
      end
    end
  endtask

  // Reset asserted between edges while outputs are high; must clear at once
  task automatic test_async_reset();
    do_reset();
    bus.LOAD_IN = 3'b010;
    bus.DIV_IN[1*W +: W] = W'(3);
    repeat (3) edge_step();
    bus.LOAD_IN = 3'b000;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (bus.CLK_OUT !== 3'b000) begin
      failures++;
      $display("FAIL areset_clk got %b exp %b", bus.CLK_OUT, 3'b000);
    end
    checks++;
    if (bus.TICK_OUT !== 3'b000) begin
      failures++;
      $display("FAIL areset_tick got %b exp %b", bus.TICK_OUT, 3'b000);
    end
    checks++;
    if (bus.PEND_OUT !== 3'b000) begin
      failures++;
      $display("FAIL areset_pend got %b exp %b", bus.PEND_OUT, 3'b000);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    test_defaults("post_reset");
  endtask

  initial begin
    bus.ENABLE_IN = 3'b111;
    bus.LOAD_IN   = 3'b000;
    bus.DIV_IN    = '0;
    exp_clk  = '0;
    exp_tick = '0;
    exp_pend = '0;
    test_reset();
    test_defaults("defaults");
    test_odd_ratio();
    test_clamp_back_to_back();
    test_load_on_wrap();
    test_enable_gating();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
